// File: rtl/board_scan.sv
// board_scan: row-major reader of the N x N colour board reporting flood state and match count
// Ports: FAST_CLOCK sole clock, RESET sync active-high; START/SIZE request a scan of an N x N board
// (SIZE clamped to MAX_SIZE); RD_ROW/RD_COL/RD_DATA form the registered board read port, data one
// cycle after the address; BUSY/DONE track the scan; FLOODED/MATCH_COUNT/HIST are held until the next START.
// Build option BOARD_SCAN_HIST_EN enables the per-colour HIST counters; otherwise HIST is 0.
module board_scan #(
    parameter int MAX_SIZE = 26,
    parameter int CNT_W = 10
) (
    input  logic FAST_CLOCK,
    input  logic RESET,
    input  logic START,
    input  logic [4:0] SIZE,
    output logic [4:0] RD_ROW,
    output logic [4:0] RD_COL,
    input  logic [2:0] RD_DATA,
    output logic BUSY,
    output logic DONE,
    output logic FLOODED,
    output logic [CNT_W-1:0] MATCH_COUNT,
    output logic [8*CNT_W-1:0] HIST
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;
    localparam logic [4:0] MAX_N = 5'(MAX_SIZE);
    state_t state, state_next;
    logic [4:0] n_q, n_start;
    logic accept, last_addr, vld, first, flood;
    logic [2:0] ref_q;
    assign n_start = (SIZE > MAX_N) ? MAX_N : SIZE;
    assign last_addr = (RD_ROW == n_q - 5'd1) && (RD_COL == n_q - 5'd1);
    always_ff @(posedge FAST_CLOCK)
        state <= RESET ? IDLE : state_next;
    always_comb begin
        state_next = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                accept = START;
                state_next = !START ? IDLE : (n_start == 5'd0) ? FINISH : SCAN;
            end
            SCAN: state_next = last_addr ? DRAIN : SCAN;
            DRAIN: state_next = FINISH;
            default: state_next = IDLE;
        endcase
    end
    // vld marks that RD_DATA now carries the cell addressed during the previous SCAN cycle
    always_ff @(posedge FAST_CLOCK) begin
        if (RESET) begin
            n_q <= '0;
            RD_ROW <= '0;
            RD_COL <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            FLOODED <= 1'b0;
            MATCH_COUNT <= '0;
            vld <= 1'b0;
            first <= 1'b0;
            flood <= 1'b0;
            ref_q <= '0;
        end else begin
            DONE <= state == FINISH;
            vld <= state == SCAN;
            if (accept) begin
                n_q <= n_start;
                RD_ROW <= '0;
                RD_COL <= '0;
                BUSY <= 1'b1;
                FLOODED <= 1'b0;
                MATCH_COUNT <= '0;
                first <= 1'b1;
                flood <= 1'b1;
            end
            if (state == SCAN && !last_addr) begin
                RD_COL <= (RD_COL == n_q - 5'd1) ? 5'd0 : RD_COL + 5'd1;
                RD_ROW <= (RD_COL == n_q - 5'd1) ? RD_ROW + 5'd1 : RD_ROW;
            end
            if (vld) begin
                first <= 1'b0;
                if (first) begin
                    ref_q <= RD_DATA;
                    MATCH_COUNT <= CNT_W'(1);
                    flood <= 1'b1;
                end else if (RD_DATA == ref_q) begin
                    MATCH_COUNT <= MATCH_COUNT + CNT_W'(1);
                end else begin
                    flood <= 1'b0;
                end
            end
            if (state == FINISH) begin
                BUSY <= 1'b0;
                FLOODED <= flood;
            end
        end
    end
`ifdef BOARD_SCAN_HIST_EN
    logic [CNT_W-1:0] hist_q [8];
    always_ff @(posedge FAST_CLOCK) begin
        if (RESET || accept)
            hist_q <= '{default: '0};
        else if (vld)
            hist_q[RD_DATA] <= hist_q[RD_DATA] + CNT_W'(1);
    end
    for (genvar c = 0; c < 8; c++) begin : g_hist
        assign HIST[c*CNT_W +: CNT_W] = hist_q[c];
    end
`else
    assign HIST = '0;
`endif
endmodule

// File: tb/tb_board_scan.sv
// tb_board_scan: self-checking bench for board_scan with a registered board memory model and result scoreboard
module tb_board_scan;
    localparam int CW = 10;
    typedef struct {
        int lat;
        logic fl;
        int cnt;
        logic [8*CW-1:0] hist;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] size = 5'd0;
    logic [4:0] rd_row, rd_col;
    logic [2:0] rd_data = 3'd0;
    logic busy, done, flooded;
    logic [CW-1:0] match_count;
    logic [8*CW-1:0] hist;
    logic [2:0] bd [26][26];
    int checks = 0, failures = 0;
    exp_t sb[$];
    exp_t last_e;
    int tr_row[$], tr_col[$];

    board_scan dut (
        .FAST_CLOCK(clk), .RESET(rst), .START(start), .SIZE(size),
        .RD_ROW(rd_row), .RD_COL(rd_col), .RD_DATA(rd_data),
        .BUSY(busy), .DONE(done), .FLOODED(flooded),
        .MATCH_COUNT(match_count), .HIST(hist)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        rd_data <= (rd_row < 5'd26 && rd_col < 5'd26) ? bd[rd_row][rd_col] : 3'd7;

    always @(negedge clk)
        if (busy) begin
            tr_row.push_back(int'(rd_row));
            tr_col.push_back(int'(rd_col));
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    task automatic fill(input logic [2:0] c);
        for (int i = 0; i < 26; i++)
            for (int j = 0; j < 26; j++)
                bd[i][j] = c;
    endtask

    function automatic exp_t model(input int n);
        exp_t e;
        logic [2:0] r;
        e.lat = (n == 0) ? 1 : n * n + 2;
        e.fl = 1'b1;
        e.cnt = 0;
        e.hist = '0;
        r = bd[0][0];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                if (bd[i][j] == r) e.cnt++;
                else e.fl = 1'b0;
`ifdef BOARD_SCAN_HIST_EN
                e.hist[int'(bd[i][j])*CW +: CW] = e.hist[int'(bd[i][j])*CW +: CW] + 10'd1;
`endif
            end
        return e;
    endfunction

    task automatic quiet(input int cyc, input string tag);
        int d = 0;
        repeat (cyc) begin
            tick();
            if (done) d++;
        end
        chk(tag, d, 0);
    endtask

    task automatic run_scan(input logic [4:0] sz, input int poke, input string tag);
        int n, lat, mr, mc;
        exp_t e;
        n = (sz > 5'd26) ? 26 : int'(sz);
        sb.push_back(model(n));
        tr_row.delete();
        tr_col.delete();
        size = sz;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 1000) begin
            start = (lat == poke);
            tick();
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        last_e = e;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_flooded"}, flooded, e.fl);
        chk({tag, "_count"}, match_count, e.cnt);
        chk({tag, "_hist"}, hist, e.hist);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_busylen"}, tr_row.size(), e.lat);
        mr = 0;
        mc = 0;
        foreach (tr_row[i]) begin
            if (tr_row[i] > mr) mr = tr_row[i];
            if (tr_col[i] > mc) mc = tr_col[i];
        end
        chk({tag, "_maxrow"}, mr, (n == 0) ? 0 : n - 1);
        chk({tag, "_maxcol"}, mc, (n == 0) ? 0 : n - 1);
    endtask

    initial begin
        int lat;
        fill(3'd0);
        repeat (3) tick();
        chk("rst_row", rd_row, 0);
        chk("rst_col", rd_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flooded", flooded, 0);
        chk("rst_count", match_count, 0);
        chk("rst_hist", hist, 0);
        rst = 1'b0;
        tick();

        fill(3'd3);
        run_scan(5'd2, -1, "n2");
        for (int i = 0; i < 4; i++) begin
            chk("n2_addr_row", tr_row[i], i / 2);
            chk("n2_addr_col", tr_col[i], i % 2);
        end

        fill(3'd1);
        bd[2][1] = 3'd4;
        run_scan(5'd3, -1, "n3");
        quiet(6, "n3_single_done");
        chk("n3_hold_flooded", flooded, last_e.fl);
        chk("n3_hold_count", match_count, last_e.cnt);
        chk("n3_hold_hist", hist, last_e.hist);

        run_scan(5'd0, -1, "n0");
        chk("n0_row", rd_row, 0);
        chk("n0_col", rd_col, 0);

        fill(3'd0);
        run_scan(5'd31, -1, "n31");
        chk("n31_row", rd_row, 25);
        chk("n31_col", rd_col, 25);

        for (int i = 0; i < 26; i++)
            for (int j = 0; j < 26; j++)
                bd[i][j] = 3'($urandom_range(0, 7));
        bd[3][2] = bd[0][0];
        run_scan(5'd5, 3, "n5_ignored_start");
        quiet(35, "n5_not_queued");

        fill(3'd2);
        size = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", match_count, 0);
        chk("midrst_row", rd_row, 0);
        tick();
        chk("midrst_idle_done", done, 0);
        chk("midrst_idle_busy", busy, 0);
        run_scan(5'd4, -1, "after_rst");

        fill(3'd3);
        size = 5'd2;
        start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("held_lat1", lat, 6);
        chk("held_flooded1", flooded, 1);
        chk("held_count1", match_count, 4);
        tick();
        chk("held_restart_busy", busy, 1);
        chk("held_clr_flooded", flooded, 0);
        chk("held_clr_count", match_count, 0);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("held_lat2", lat, 6);
        chk("held_flooded2", flooded, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
